ripple_count_sampler: RTL and testbench

- Consumer stage for the 4-bit asynchronous ripple counter. The ripple counter's bits settle at different times relative to `clk`.
- The block synchronises the raw count into the `clk` domain and filters out transient mid-ripple codes.
- It converts each accepted change into a modulo-2^CNT_W delta and accumulates the deltas into a wide saturating total.
- It raises a sticky threshold flag for software or control logic downstream.

---
 rtl/ripple_count_sampler.sv | 179 +++++++++++++++++
 tb/tb_ripple_count_sampler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// -----------------------------------------------------------------------------
// ripple_count_sampler
//
// Consumer stage for an asynchronous ripple counter. The raw count is brought
// into the clk domain and filtered so that codes seen while the counter is
// mid-ripple are never accepted. Each accepted change becomes a modulo-2^CNT_W
// increment that is accumulated into a wide saturating total. A sticky flag
// reports when the total reaches a programmable threshold.
//
// Ports:
//   clk          system clock; all state updates on its rising edge
//   rst          synchronous, active-high reset
//   cnt_in       raw ripple counter value, asynchronous to clk
//   enable       1 = add accepted increments to total; 0 = drop them
//   clear        synchronous clear of total, overflow and thresh_hit
//   threshold    compare value for thresh_hit; 0 disables the flag
//   delta        last accepted increment
//   delta_valid  one-cycle pulse when delta (and possibly total) updates
//   total        saturating accumulated count
//   overflow     sticky; total has saturated
//   thresh_hit   sticky; total >= threshold
//   baseline_ok  high once the first stable value has been captured
// -----------------------------------------------------------------------------
module ripple_count_sampler #(
    parameter int CNT_W         = 4,
    parameter int ACC_W         = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             enable,
    input  logic             clear,
    input  logic [ACC_W-1:0] threshold,
    output logic [CNT_W-1:0] delta,
    output logic             delta_valid,
    output logic [ACC_W-1:0] total,
    output logic             overflow,
    output logic             thresh_hit,
    output logic             baseline_ok
);

    localparam int               RUN_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_NEED  = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [ACC_W-1:0] TOTAL_MAX = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] s1, s2, s3;
    logic [RUN_W-1:0] run_len;
    logic [CNT_W-1:0] last_val;

    logic             stable;
    logic             capture;
    logic             accept;
    logic [CNT_W-1:0] delta_d;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] total_d;
    logic             overflow_d;
    logic             thresh_d;

    // s1 may go metastable, so only s2/s3 are looked at. A code is trusted
    // once s2 has matched s3 for enough consecutive cycles.
    assign stable = (s2 == s3) && (run_len >= RUN_NEED);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            INIT: begin
                if (stable) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                accept = stable && (s2 != last_val);
            end
            default: state_d = INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator next values
    // ------------------------------------------------------------------
    always_comb begin
        // Unsigned subtraction in CNT_W bits wraps naturally (14 -> 1 = 3).
        delta_d    = s2 - last_val;
        sum_w      = (ACC_W+1)'(total) + (ACC_W+1)'(delta_d);
        total_d    = total;
        overflow_d = overflow;
        if (clear) begin
            total_d    = '0;
            overflow_d = 1'b0;
        end else if (accept && enable) begin
            if (sum_w[ACC_W]) begin
                total_d    = TOTAL_MAX;
                overflow_d = 1'b1;
            end else begin
                total_d = sum_w[ACC_W-1:0];
            end
        end
        // Compared against the next total every cycle, so a threshold that is
        // lowered below an unchanged total still sets the flag.
        if (clear) begin
            thresh_d = 1'b0;
        end else begin
            thresh_d = thresh_hit || ((threshold != '0) && (total_d >= threshold));
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the sync chain shifts by one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            run_len     <= '0;
            last_val    <= '0;
            delta       <= '0;
            delta_valid <= 1'b0;
            total       <= '0;
            overflow    <= 1'b0;
            thresh_hit  <= 1'b0;
            baseline_ok <= 1'b0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            s3 <= s2;

            if (s2 != s3) begin
                run_len <= '0;
            end else if (run_len != RUN_MAX) begin
                run_len <= run_len + 1'b1;
            end

            delta_valid <= 1'b0;
            if (capture) begin
                last_val    <= s2;
                baseline_ok <= 1'b1;
            end else if (accept) begin
                last_val    <= s2;
                delta       <= delta_d;
                delta_valid <= 1'b1;
            end

            total      <= total_d;
            overflow   <= overflow_d;
            thresh_hit <= thresh_d;
        end
    end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// -----------------------------------------------------------------------------
// tb_ripple_count_sampler
//
// Drives directed scenarios followed by randomised counter activity. Every
// cycle all outputs are compared with a behavioural model that keeps the
// history of sampled inputs in a queue and applies the accept/accumulate rules
// with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_ripple_count_sampler;

    localparam int CNT_W  = 4;
    localparam int ACC_W  = 8;
    localparam int STABLE = 2;
    localparam int MODV   = 1 << CNT_W;
    localparam int MAXV   = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cnt_in;
    logic             enable;
    logic             clear;
    logic [ACC_W-1:0] threshold;
    logic [CNT_W-1:0] delta;
    logic             delta_valid;
    logic [ACC_W-1:0] total;
    logic             overflow;
    logic             thresh_hit;
    logic             baseline_ok;

    ripple_count_sampler #(
        .CNT_W         (CNT_W),
        .ACC_W         (ACC_W),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_in      (cnt_in),
        .enable      (enable),
        .clear       (clear),
        .threshold   (threshold),
        .delta       (delta),
        .delta_valid (delta_valid),
        .total       (total),
        .overflow    (overflow),
        .thresh_hit  (thresh_hit),
        .baseline_ok (baseline_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // m_hist holds the values cnt_in had at successive clock edges. A value is
    // trusted when it appears in STABLE+1 consecutive entries, counted from
    // two edges back (the synchroniser delay). Reset leaves three zero samples
    // behind it and nothing older.
    int m_hist[$];
    bit m_base, m_dv, m_ovf, m_th;
    int m_last, m_delta, m_total;

    task automatic model_edge();
        int n;
        int sv;
        bit stable;
        if (rst) begin
            m_hist  = {0, 0, 0};
            m_base  = 0;
            m_last  = 0;
            m_delta = 0;
            m_dv    = 0;
            m_total = 0;
            m_ovf   = 0;
            m_th    = 0;
            return;
        end
        n      = m_hist.size();
        sv     = m_hist[n-2];
        stable = (n - 1 >= STABLE + 1);
        if (stable) begin
            for (int i = n - 2 - STABLE; i < n - 1; i++) begin
                if (m_hist[i] != sv) stable = 0;
            end
        end
        m_dv = 0;
        if (!m_base) begin
            if (stable) begin
                m_base = 1;
                m_last = sv;
            end
        end else if (stable && sv != m_last) begin
            m_delta = (sv - m_last + MODV) % MODV;
            m_last  = sv;
            m_dv    = 1;
            if (enable && !clear) begin
                m_total = m_total + m_delta;
                if (m_total > MAXV) begin
                    m_total = MAXV;
                    m_ovf   = 1;
                end
            end
        end
        if (clear) begin
            m_total = 0;
            m_ovf   = 0;
            m_th    = 0;
        end else if (threshold != 0 && m_total >= int'(threshold)) begin
            m_th = 1;
        end
        m_hist.push_back(int'(cnt_in));
        while (m_hist.size() > STABLE + 4) void'(m_hist.pop_front());
    endtask

    // One clock: update the model at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("delta",       int'(delta),       m_delta);
        check("delta_valid", int'(delta_valid), int'(m_dv));
        check("total",       int'(total),       m_total);
        check("overflow",    int'(overflow),    int'(m_ovf));
        check("thresh_hit",  int'(thresh_hit),  int'(m_th));
        check("baseline_ok", int'(baseline_ok), int'(m_base));
    endtask

    // Hold cnt_in at val for n cycles; optionally pulse clear on cycle clr_at.
    int h_pulses, h_step, h_delta, h_total, h_th;

    task automatic hold(input int val, input int n, input int clr_at);
        h_pulses = 0;
        h_step   = 0;
        h_delta  = -1;
        h_total  = -1;
        h_th     = -1;
        cnt_in   = CNT_W'(val);
        for (int i = 1; i <= n; i++) begin
            clear = (i == clr_at);
            step();
            if (delta_valid) begin
                h_pulses++;
                h_step  = i;
                h_delta = int'(delta);
                h_total = int'(total);
                h_th    = int'(thresh_hit);
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        int v;
        m_hist    = {0, 0, 0};
        rst       = 1'b1;
        cnt_in    = '0;
        enable    = 1'b1;
        clear     = 1'b0;
        threshold = '0;

        // Reset with the counter toggling underneath it.
        for (int i = 0; i < 2; i++) begin
            cnt_in = CNT_W'($urandom_range(0, MODV - 1));
            step();
            check("rst_dv",   int'(delta_valid), 0);
            check("rst_base", int'(baseline_ok), 0);
            check("rst_total", int'(total),      0);
        end
        rst = 1'b0;

        // Baseline, then a single +2 step with the nominal latency.
        hold(5, 12, 0);
        check("base_ok", int'(baseline_ok), 1);
        hold(5, 1, 1);
        hold(7, 8, 0);
        check("lat_pulses", h_pulses, 1);
        check("lat_step",   h_step,   5);
        check("lat_delta",  h_delta,  2);
        check("lat_total",  h_total,  2);

        // Wrap-around.
        hold(14, 8, 0);
        hold(14, 1, 1);
        hold(1, 8, 0);
        check("wrap_delta", int'(delta), 3);
        check("wrap_total", int'(total), 3);
        hold(2, 8, 0);
        check("wrap2_delta", int'(delta), 1);
        check("wrap2_total", int'(total), 4);

        // One-cycle glitch must be ignored.
        hold(8, 8, 0);
        hold(8, 1, 1);
        hold(12, 1, 0);
        hold(8, 8, 0);
        check("glitch_pulses", h_pulses,    0);
        check("glitch_total",  int'(total), 0);
        hold(9, 8, 0);
        check("glitch_delta", int'(delta), 1);

        // Threshold then saturation.
        threshold = ACC_W'(10);
        hold(9, 1, 1);
        hold(13, 8, 0);
        hold(1, 8, 0);
        check("thr_below", int'(thresh_hit), 0);
        hold(3, 8, 0);
        check("thr_total", h_total, 10);
        check("thr_same_edge", h_th, 1);
        v = 3;
        for (int i = 0; i < 18; i++) begin
            v = (v + 15) % MODV;
            hold(v, 8, 0);
        end
        check("sat_total", int'(total),    MAXV);
        check("sat_ovf",   int'(overflow), 1);

        // clear coinciding with an accept, then enable=0.
        hold((v + 3) % MODV, 8, 5);
        check("clr_pulses", h_pulses, 1);
        check("clr_delta",  h_delta,  3);
        check("clr_total",  h_total,  0);
        check("clr_ovf",    int'(overflow), 0);
        enable = 1'b0;
        hold((v + 7) % MODV, 8, 0);
        check("dis_pulses", h_pulses,    1);
        check("dis_delta",  h_delta,     4);
        check("dis_total",  int'(total), 0);
        enable = 1'b1;

        // Randomised activity against the model.
        for (int it = 0; it < 800; it++) begin
            int len;
            int clr;
            len = $urandom_range(1, 6);
            clr = ($urandom_range(0, 15) == 0) ? $urandom_range(1, len) : 0;
            rst    = ($urandom_range(0, 60) == 0);
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 40) == 0) threshold = ACC_W'($urandom_range(0, MAXV));
            hold($urandom_range(0, MODV - 1), len, clr);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
